// File: rtl/wnr_pack_pkg.sv
// Shared constants and helpers for the frame packer.
// Used by wnr_frame_packer, its interface and its output register.
package wnr_pack_pkg;

   localparam int unsigned FRAME_CNT_W = 16;

   // Never returns 0, so a counter derived from it always has at least one bit.
   function automatic int unsigned clog2(input int unsigned val);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(val)) begin
         res = res + 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

endpackage

// File: rtl/wnr_frame_packer_if.sv
// Sample-in / packed-word-out bus of the frame packer.
// slave: packer side. master: driver/sink side.
interface wnr_frame_packer_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned RATIO = 4
);
   import wnr_pack_pkg::*;

   logic               in_valid;
   logic [W-1:0]       in_data;
   logic               in_ready;
   logic               flush;
   logic               out_valid;
   logic [W*RATIO-1:0] out_data;
   logic               out_last;
   logic               out_ready;

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/wnr_pack_out_reg.sv
// Output holding register: one word plus its last flag, valid/ready on the drain side.
// The parent only asserts load_i when the register is empty or draining.
module wnr_pack_out_reg
   import wnr_pack_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [DW-1:0] data_i,
   input  logic          last_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          last_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/wnr_frame_packer.sv
// Packs RATIO W-bit samples per output word and tags the last word of each frame.
// Define WNR_PACK_FRAME_CNT_EN to add the frame_cnt_o completed-frame counter.
module wnr_frame_packer
   import wnr_pack_pkg::*;
#(
   parameter int unsigned W           = 8,
   parameter int unsigned RATIO       = 4,
   parameter int unsigned FRAME_WORDS = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   wnr_frame_packer_if.slave      bus_io
`ifdef WNR_PACK_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o
`endif
);

   localparam int unsigned LANE_W     = clog2(RATIO);
   localparam int unsigned WORD_CNT_W = clog2(FRAME_WORDS);
   localparam int unsigned DW         = W * RATIO;

   localparam logic [LANE_W-1:0]     LaneMax = LANE_W'(RATIO - 1);
   localparam logic [WORD_CNT_W-1:0] WordMax = WORD_CNT_W'(FRAME_WORDS - 1);

   logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [DW-1:0]         acc_q, acc_d;

   logic          out_valid, out_last;
   logic [DW-1:0] out_data;
   logic          out_free, lane_last, in_ready, accept, flush_svc;
   logic          load, load_last;
   logic [DW-1:0] load_data;

   // A word load may land in the same cycle the held word drains.
   assign out_free  = ~out_valid | bus_io.out_ready;
   assign lane_last = (lane_cnt_q == LaneMax);
   assign in_ready  = ~flush_pend_q & (~lane_last | out_free);
   assign accept    = bus_io.in_valid & in_ready;
   assign flush_svc = flush_pend_q & out_free;

   always_comb begin
      lane_cnt_d   = lane_cnt_q;
      word_cnt_d   = word_cnt_q;
      acc_d        = acc_q;
      flush_pend_d = flush_pend_q | bus_io.flush;
      load         = 1'b0;
      load_last    = 1'b0;
      load_data    = acc_q | (DW'(bus_io.in_data) << ((RATIO - 1) * W));
      // in_ready is low while a flush is pending, so service and accept never coincide.
      if (flush_svc) begin
         flush_pend_d = 1'b0;
         lane_cnt_d   = '0;
         word_cnt_d   = '0;
         acc_d        = '0;
         load         = (lane_cnt_q != '0);
         load_data    = acc_q;
         load_last    = 1'b1;
      end else if (accept) begin
         if (lane_last) begin
            load       = 1'b1;
            load_last  = (word_cnt_q == WordMax);
            lane_cnt_d = '0;
            acc_d      = '0;
            word_cnt_d = load_last ? '0 : word_cnt_q + WORD_CNT_W'(1);
         end else begin
            acc_d[lane_cnt_q*W +: W] = bus_io.in_data;
            lane_cnt_d               = lane_cnt_q + LANE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt_q   <= '0;
         word_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         lane_cnt_q   <= lane_cnt_d;
         word_cnt_q   <= word_cnt_d;
         flush_pend_q <= flush_pend_d;
         acc_q        <= acc_d;
      end
   end

   wnr_pack_out_reg #(
      .DW (DW)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .data_i  (load_data),
      .last_i  (load_last),
      .ready_i (bus_io.out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (out_last)
   );

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid;
   assign bus_io.out_data  = out_data;
   assign bus_io.out_last  = out_last;

`ifdef WNR_PACK_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (out_valid & bus_io.out_ready & out_last) begin
         frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_wnr_frame_packer.sv
// Scoreboard bench for wnr_frame_packer (W=8, RATIO=4, FRAME_WORDS=4).
// A sample-list model predicts every packed word; a negedge monitor compares transfers.
module tb_wnr_frame_packer;

   localparam int unsigned W     = 8;
   localparam int unsigned RATIO = 4;
   localparam int unsigned FW    = 4;
   localparam int unsigned DW    = W * RATIO;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wnr_frame_packer_if #(.W(W), .RATIO(RATIO)) bus_if ();

`ifdef WNR_PACK_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   wnr_frame_packer #(
      .W           (W),
      .RATIO       (RATIO),
      .FRAME_WORDS (FW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_io      (bus_if)
`ifdef WNR_PACK_FRAME_CNT_EN
      ,
      .frame_cnt_o (frame_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   logic [DW:0]  exp_q[$];  // {last, data}
   logic [W-1:0] part[$];
   int           frame_words = 0;
   int           words_out = 0;
   int           frames_done = 0;
   logic [DW:0]  last_word = '0;
   bit           rate_chk = 1'b0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endfunction

   // Reference model: a word is the next RATIO accepted samples, first in the low lane.
   function automatic void model_emit(input bit last);
      logic [DW-1:0] w;
      w = '0;
      foreach (part[i]) w[i*W +: W] = part[i];
      exp_q.push_back({last, w});
      part.delete();
      frame_words = last ? 0 : frame_words + 1;
   endfunction

   function automatic void model_sample(input logic [W-1:0] d);
      part.push_back(d);
      if (part.size() == RATIO) model_emit(frame_words == FW - 1);
   endfunction

   function automatic void model_flush();
      if (part.size() != 0) model_emit(1'b1);
      else frame_words = 0;
   endfunction

   logic [DW:0] prev;
   bit          hold = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         part.delete();
         frame_words = 0;
         frames_done = 0;
         hold        = 1'b0;
      end else begin
         if (hold) check("hold_stable", {bus_if.out_valid, bus_if.out_last, bus_if.out_data},
                         {1'b1, prev});
         hold = bus_if.out_valid & ~bus_if.out_ready;
         prev = {bus_if.out_last, bus_if.out_data};
         if (bus_if.out_valid && bus_if.out_ready) begin
            words_out++;
            last_word = {bus_if.out_last, bus_if.out_data};
            if (bus_if.out_last) frames_done++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got %0h, want none", last_word);
            end else begin
               check("word", last_word, exp_q.pop_front());
            end
         end
         if (rate_chk && bus_if.in_valid) check("no_bubble", bus_if.in_ready, 1);
         if (bus_if.in_valid && bus_if.in_ready) model_sample(bus_if.in_data);
         if (bus_if.flush) model_flush();
      end
   end

   task automatic send(input logic [W-1:0] d);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = bus_if.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus_if.in_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic pulse_flush();
      bus_if.flush = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flush = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus_if.in_valid  = 1'b0;
      bus_if.flush     = 1'b0;
      bus_if.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus_if.out_valid) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int v;
      int a;
      int w0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.flush     = 1'b0;
      bus_if.out_ready = 1'b0;
      #1;
      check("rst_out_valid", bus_if.out_valid, 0);
      check("rst_out_data", bus_if.out_data, 0);
      check("rst_out_last", bus_if.out_last, 0);
      check("rst_in_ready", bus_if.in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full rate, one frame of four words.
      bus_if.out_ready = 1'b1;
      rate_chk = 1'b1;
      w0 = words_out;
      for (int d = 1; d <= 16; d++) send(W'(d));
      rate_chk = 1'b0;
      drain();
      check("t1_words", words_out - w0, 4);
      check("t1_last_word", last_word, {1'b1, 32'h100F0E0D});
      check("t1_frames", frames_done, 1);

      // Backpressure: one held word plus RATIO-1 lanes, then stall.
      bus_if.out_ready = 1'b0;
      v = 1;
      a = 0;
      for (int c = 0; c < 20; c++) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = W'(v);
         @(negedge clk);
         if (bus_if.in_ready) begin
            v++;
            a++;
         end
         @(posedge clk);
         #1;
      end
      bus_if.in_valid = 1'b0;
      check("bp_accepted", a, 2 * RATIO - 1);
      bus_if.out_ready = 1'b1;
      while (v <= 16) begin
         send(W'(v));
         v++;
      end
      drain();
      check("t2_last_word", last_word, {1'b1, 32'h100F0E0D});

      // Partial flush, then a fresh frame.
      send(8'hA1);
      send(8'hA2);
      pulse_flush();
      repeat (3) @(posedge clk);
      #1;
      check("flush_partial", last_word, {1'b1, 32'h0000A2A1});
      for (int d = 8'h11; d <= 8'h14; d++) send(W'(d));
      drain();
      check("after_flush", last_word, {1'b0, 32'h14131211});

      // Flush on a word boundary emits nothing extra.
      for (int d = 8'h21; d <= 8'h24; d++) send(W'(d));
      drain();
      w0 = words_out;
      pulse_flush();
      repeat (4) @(posedge clk);
      #1;
      check("boundary_flush_none", words_out - w0, 0);
      for (int d = 8'h31; d <= 8'h40; d++) send(W'(d));
      drain();
      check("boundary_next_last", last_word, {1'b1, 32'h403F3E3D});

      // Reset with a word held and two lanes filled.
      bus_if.out_ready = 1'b0;
      for (int d = 8'h51; d <= 8'h56; d++) send(W'(d));
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", bus_if.out_valid, 0);
      check("rst_mid_ready", bus_if.in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_if.out_ready = 1'b1;
      for (int d = 8'h61; d <= 8'h64; d++) send(W'(d));
      drain();
      check("rst_fresh_word", last_word, {1'b0, 32'h64636261});

      // Randomized traffic, backpressure and flushes.
      for (int c = 0; c < 3000; c++) begin
         bus_if.in_valid  = ($urandom_range(0, 3) != 0);
         bus_if.in_data   = W'($urandom);
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         bus_if.flush     = ($urandom_range(0, 40) == 0);
         @(posedge clk);
         #1;
      end
      drain();
      pulse_flush();
      drain();
      check("final_partial_empty", part.size(), 0);
`ifdef WNR_PACK_FRAME_CNT_EN
      check("frame_cnt", frame_cnt, 16'(frames_done));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
